// File: rtl/rv32i_pipe_ctrl.sv
// RV32I pipeline hazard/stall/flush controller with drain handshake.
// Optional perf counters enabled by defining RV32I_PIPE_CTRL_PERF_EN.
module rv32i_pipe_ctrl #(
    parameter int unsigned LD_USE_STALL = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        id_valid_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_uses_rs1_i,
    input  logic        id_uses_rs2_i,
    input  logic        ex_valid_i,
    input  logic        ex_is_load_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_redirect_i,
    input  logic        mem_valid_i,
    input  logic        wb_valid_i,
    input  logic        imem_ready_i,
    input  logic        dmem_busy_i,
    input  logic        drain_req_i,
    output logic        drain_busy_o,
    output logic        drain_done_o,
    output logic        pc_hold_o,
    output logic [3:0]  hold_o,
    output logic [3:0]  flush_o,
    output logic [31:0] perf_stall_o,
    output logic [31:0] perf_flush_o
);

    typedef enum logic [1:0] {
        RUN,
        LDSTALL,
        DRAIN,
        DONE
    } state_e;

    localparam logic [1:0] CNT_INIT = 2'(LD_USE_STALL - 1);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       load_use;

    assign load_use = id_valid_i & ex_valid_i & ex_is_load_i
                    & (ex_rd_i != 5'd0)
                    & ((id_uses_rs1_i & (id_rs1_i == ex_rd_i))
                     | (id_uses_rs2_i & (id_rs2_i == ex_rd_i)));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_hold_o    = 1'b0;
        hold_o       = 4'b0000;
        flush_o      = 4'b0000;
        drain_busy_o = 1'b0;
        drain_done_o = 1'b0;
        unique case (state_q)
            RUN: begin
                if (dmem_busy_i) begin
                    pc_hold_o = 1'b1;
                    hold_o    = 4'b0111;
                    flush_o   = 4'b1000;
                end else begin
                    if (ex_redirect_i) begin
                        flush_o = 4'b0011;
                    end else if (load_use) begin
                        pc_hold_o = 1'b1;
                        hold_o    = 4'b0001;
                        flush_o   = 4'b0010;
                        if (LD_USE_STALL > 1) begin
                            state_d = LDSTALL;
                            cnt_d   = CNT_INIT;
                        end
                    end else if (!imem_ready_i) begin
                        pc_hold_o = 1'b1;
                        flush_o   = 4'b0001;
                    end
                    // A drain request outranks entering a load-use stall.
                    if (drain_req_i) begin
                        state_d = DRAIN;
                        cnt_d   = cnt_q;
                    end
                end
            end
            LDSTALL: begin
                if (dmem_busy_i) begin
                    pc_hold_o = 1'b1;
                    hold_o    = 4'b0111;
                    flush_o   = 4'b1000;
                end else begin
                    pc_hold_o = 1'b1;
                    hold_o    = 4'b0001;
                    flush_o   = 4'b0010;
                    cnt_d     = cnt_q - 2'd1;
                    if (cnt_q <= 2'd1) begin
                        state_d = RUN;
                        cnt_d   = 2'd0;
                    end
                end
            end
            DRAIN: begin
                drain_busy_o = 1'b1;
                if (dmem_busy_i) begin
                    pc_hold_o = 1'b1;
                    hold_o    = 4'b0111;
                    flush_o   = 4'b1000;
                end else begin
                    pc_hold_o = 1'b1;
                    flush_o   = 4'b0011;
                    if (!ex_valid_i && !mem_valid_i && !wb_valid_i) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                drain_done_o = 1'b1;
                pc_hold_o    = 1'b1;
                state_d      = RUN;
            end
            default: begin
                state_d = RUN;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef RV32I_PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            if (pc_hold_o) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (flush_o[1:0] != 2'b00) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_o = perf_stall_q;
    assign perf_flush_o = perf_flush_q;
`else
    assign perf_stall_o = 32'd0;
    assign perf_flush_o = 32'd0;
`endif

endmodule

// File: doc/rv32i_pipe_ctrl.md
RV32I_PIPE_CTRL -- requirements
Module: rv32i_pipe_ctrl

Interface
REQ-001 SHALL have parameter LD_USE_STALL, default 1, range 1..3: bubble count inserted on a load-use hazard.
REQ-002 SHALL have port clk_i, input, 1: the single clock.
REQ-003 SHALL have port rst_ni, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have inputs id_valid_i (1), id_rs1_i (5), id_rs2_i (5), id_uses_rs1_i (1), id_uses_rs2_i (1): the decode-stage instruction and its source operands.
REQ-005 SHALL have inputs ex_valid_i (1), ex_is_load_i (1), ex_rd_i (5), ex_redirect_i (1): the EX-stage instruction; ex_redirect_i means a taken branch or jump was resolved.
REQ-006 SHALL have inputs mem_valid_i (1), wb_valid_i (1): occupancy of EX/MEM and MEM/WB.
REQ-007 SHALL have inputs imem_ready_i (1), dmem_busy_i (1): fetch data available and data-memory wait.
REQ-008 SHALL have inputs drain_req_i (1) and outputs drain_busy_o (1), drain_done_o (1): pipeline-drain handshake for fence.i and traps.
REQ-009 SHALL have outputs pc_hold_o (1), hold_o (4), flush_o (4): bit 0 is IF/ID, 1 is ID/EX, 2 is EX/MEM, 3 is MEM/WB.
REQ-010 SHALL have outputs perf_stall_o (32) and perf_flush_o (32): performance counters.

Function
REQ-011 SHALL implement FSM states RUN, LDSTALL, DRAIN and DONE.
REQ-012 SHALL never assert hold_o[n] and flush_o[n] together in the same cycle.
REQ-013 SHALL define load-use as id_valid_i & ex_valid_i & ex_is_load_i & ex_rd_i!=0 & ((id_uses_rs1_i & id_rs1_i==ex_rd_i) | (id_uses_rs2_i & id_rs2_i==ex_rd_i)).
REQ-014 SHALL, in RUN, apply these rules in priority order:
- dmem_busy_i: pc_hold_o=1, hold_o[2:0]=1, flush_o[3]=1.
- ex_redirect_i: flush_o[1:0]=3.
- load-use: pc_hold_o=1, hold_o[0]=1, flush_o[1]=1.
- !imem_ready_i: pc_hold_o=1, flush_o[0]=1.
- Otherwise all outputs are 0.
REQ-015 SHALL, on load-use in RUN with LD_USE_STALL>1, load stall counter with LD_USE_STALL-1 and go to LDSTALL.
REQ-016 SHALL, in LDSTALL: drive pc_hold_o=1, hold_o[0]=1, flush_o[1]=1; decrement the counter each cycle; go to RUN in the cycle the counter reaches 0. A total of exactly LD_USE_STALL bubbles is inserted.
REQ-017 SHALL, while dmem_busy_i is high in LDSTALL or DRAIN, apply the dmem_busy rule of REQ-014 and freeze the stall counter.
REQ-018 SHALL accept drain_req_i in RUN when dmem_busy_i=0 and go to DRAIN. The same-cycle ex_redirect_i flush SHALL still be applied.
REQ-019 SHALL, in DRAIN: drive pc_hold_o=1, flush_o[1:0]=3, drain_busy_o=1; go to DONE when ex_valid_i, mem_valid_i and wb_valid_i are all 0.
REQ-020 SHALL, in DONE: pulse drain_done_o=1 for exactly one cycle with pc_hold_o=1, then return to RUN.
REQ-021 SHALL ignore drain_req_i outside RUN, and ignore load-use and imem conditions in DRAIN and DONE.
REQ-022 SHALL not gate redirect-target PC loading with pc_hold_o; fetch owns that path.
REQ-023 SHALL keep all hold/flush outputs combinational from state and inputs (zero latency); the FSM and counters are the only registers.

Reset
REQ-024 SHALL, while rst_ni=0, go to RUN, clear the stall counter and zero both perf counters; outputs follow RUN rules.
REQ-025 SHALL, on reset assertion mid-LDSTALL or mid-DRAIN, abandon the sequence with no drain_done_o pulse.

Configuration
REQ-026 SHALL, with RV32I_PIPE_CTRL_PERF_EN defined: increment perf_stall_o each cycle pc_hold_o=1, and increment perf_flush_o each cycle flush_o[1:0]!=0. Both counters wrap modulo 2^32.
REQ-027 SHALL, without RV32I_PIPE_CTRL_PERF_EN, tie perf_stall_o and perf_flush_o to 0 and instantiate no counter flops.

Verification
REQ-028 SHALL cover load-use: LD_USE_STALL=2, ex load rd=5, id rs1=5 -> pc_hold_o=1, hold_o=4'b0001, flush_o=4'b0010 for exactly 2 cycles, then all 0.
REQ-029 SHALL cover x0 and unused operands: ex load rd=0 with id rs1=0, then rd=7 with id rs2=7 and id_uses_rs2_i=0 -> no stall in either case.
REQ-030 SHALL cover redirect over load-use: ex_redirect_i=1 with a load-use hazard in the same cycle -> flush_o=4'b0011, hold_o=0, pc_hold_o=0, FSM stays in RUN.
REQ-031 SHALL cover dmem_busy mid-LDSTALL: dmem_busy_i high 3 cycles during LDSTALL -> hold_o=4'b0111, flush_o=4'b1000, counter frozen; the remaining bubble count resumes afterward.
REQ-032 SHALL cover drain: drain_req_i with ex/mem/wb valid draining over 3 cycles -> drain_busy_o=1 for those cycles, then a single-cycle drain_done_o, then RUN.
REQ-033 SHALL cover perf counters: preload perf_stall_o=32'hFFFFFFFF by forcing, one stall cycle -> 0; with the macro undefined -> both outputs stay 0.
